// File: rtl/vga_pix_feeder.sv
// Buffers wide DDR pixel words and unpacks one 24-bit RGB pixel per pix_req, flushing on vsync rise.
// Optional build macro PIX_FEED_UFLOW_CNT_EN adds a saturating underflow_cnt output.
module vga_pix_feeder #(
   parameter int WORD_W     = 128,
   parameter int FIFO_DEPTH = 16,
   parameter int FRAME_PIX  = 1228800
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              pix_req,
   output logic [23:0]       rgb_out,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              frame_start,
   output logic              frame_done,
`ifdef PIX_FEED_UFLOW_CNT_EN
   output logic [15:0]       underflow_cnt,
`endif
   output logic              underflow
);

   localparam int LANES = WORD_W / 32;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [20:0]   FRAME_LIM = 21'(FRAME_PIX);
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
   localparam logic [LW-1:0] LANE_ONE  = LW'(1);
   localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
   localparam logic [20:0]   CNT_ONE   = 21'd1;

   logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WORD_W-1:0] cur_q, cur_d;
   logic              cur_valid_q, cur_valid_d;
   logic [LW-1:0]     lane_q, lane_d;
   logic [20:0]       pix_cnt_q, pix_cnt_d;
   logic [23:0]       rgb_q, rgb_d;
   logic              vsync_q, frame_start_q, underflow_q, underflow_d;
   logic              full, empty, flush, push, pop, served, unserved;

   assign flush    = vsync && !vsync_q;
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign s_ready  = !full && !flush;
   assign push     = s_valid && s_ready;
   // A flush cycle suppresses the pop so the cleared FIFO and cur stay consistent.
   assign pop      = (!cur_valid_q || (pix_req && cur_valid_q && lane_q == LAST_LANE)) && !empty && !flush;
   assign served   = pix_req && cur_valid_q && !flush;
   assign unserved = pix_req && !cur_valid_q && !flush;

   always_comb begin
      wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      cur_d       = cur_q;
      cur_valid_d = cur_valid_q;
      lane_d      = lane_q;
      pix_cnt_d   = pix_cnt_q;
      underflow_d = underflow_q || unserved;
      rgb_d       = served ? cur_q[lane_q*32 +: 24] : 24'h000000;
      if (served && pix_cnt_q != FRAME_LIM)
         pix_cnt_d = pix_cnt_q + CNT_ONE;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         cur_valid_d = 1'b0;
         lane_d      = '0;
         pix_cnt_d   = '0;
      end else if (pop) begin
         cur_d       = mem_q[rd_ptr_q[AW-1:0]];
         cur_valid_d = 1'b1;
         lane_d      = '0;
      end else if (served) begin
         if (lane_q == LAST_LANE) begin
            cur_valid_d = 1'b0;
            lane_d      = '0;
         end else begin
            lane_d = lane_q + LANE_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         cur_valid_q   <= 1'b0;
         lane_q        <= '0;
         pix_cnt_q     <= '0;
         rgb_q         <= '0;
         vsync_q       <= 1'b1;
         frame_start_q <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         cur_valid_q   <= cur_valid_d;
         lane_q        <= lane_d;
         pix_cnt_q     <= pix_cnt_d;
         rgb_q         <= rgb_d;
         vsync_q       <= vsync;
         frame_start_q <= flush;
         underflow_q   <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q[AW-1:0]] <= s_data;
      cur_q <= cur_d;
   end

`ifdef PIX_FEED_UFLOW_CNT_EN
   logic [15:0] ucnt_q;
   always_ff @(posedge clk) begin
      if (rst)
         ucnt_q <= '0;
      else if (unserved && ucnt_q != 16'hFFFF)
         ucnt_q <= ucnt_q + 16'd1;
   end
   assign underflow_cnt = ucnt_q;
`endif

   assign rgb_out     = rgb_q;
   assign frame_start = frame_start_q;
   assign frame_done  = (pix_cnt_q == FRAME_LIM);
   assign underflow   = underflow_q;

endmodule
